seg7_scan_scheduler: RTL and testbench
======================================

Name: seg7_scan_scheduler

Overview:
- Time-multiplexes the 8-digit seven-segment display between its digit positions.
- The motion-indicator FSM and other display clients present 5-bit digit codes; this block latches them frame-atomically through a req/ack handshake, decodes them, and scans anodes with an inter-digit blanking gap to suppress ghosting.
- Sits between the display-code producers and the board's anode/cathode pins.

Parameters:
- SIMULATE, 0, 1 selects short counts for simulation.
- ON_CYC, 99_000 (SIMULATE: 4), clocks a digit is lit per slot.
- BLANK_CYC, 1_000 (SIMULATE: 1), clocks all anodes off before each slot.
- BLINK_CNT, 24_999_999 (SIMULATE: 7), half-period of blink toggle; used only with BLINK_EN.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- digits_in  in  40  8 digit codes, digit k = bits [5k+4:5k]
- dp_in  in  8  decimal point per digit, 1 = lit
- load_req  in  1  level request to load digits_in/dp_in
- load_ack  out  1  one-cycle pulse: data captured
- anode  out  8  digit enables, active-low
- seg  out  7  cathodes a..g = bit0..bit6, active-low
- dp  out  1  decimal-point cathode, active-low
- frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset values: anode=8'hFF, seg=7'h7F, dp=1, load_ack=0, frame_start=0. Display registers all 5'd23 (blank), dp regs 0, index=0, state=S_BLANK, counter=0.
- All outputs are registered. Reset assertion mid-scan forces the reset values immediately (async); a load in progress is discarded.
- States:
  - S_BLANK: anode=8'hFF. After BLANK_CYC cycles go to S_ON.
  - S_ON: anode[index]=0, seg/dp driven from the decoded display register of index. After ON_CYC cycles go to S_BLANK with index+1, 3-bit wrap 7->0.
- Slot length is BLANK_CYC+ON_CYC; a frame is 8 slots.
- Frame boundary: the last cycle of S_ON with index=7.
  - If load_req=1 in that cycle, all 8 codes and dp bits are captured together, and load_ack pulses high on the next cycle.
  - No partial updates are permitted at any time.
- Handshake rules:
  - The requester holds digits_in/dp_in stable while load_req=1, and deasserts load_req the cycle after load_ack.
  - If load_req is still high at the next boundary, it is a new request and is captured again.
  - load_req rising mid-frame waits for the boundary; worst-case latency is one frame.
- frame_start pulses in the cycle S_BLANK->S_ON for index=0, which is after any capture.
- First lit slot after reset release: digit 0 after BLANK_CYC cycles.
- Decode, code -> lit segments:
  - 0-15: standard hex glyphs, where 0=abcdef, 1=bc, 8=all, F=aefg.
  - 16-22: single segment a..g (16=a, ... 22=g).
  - 23-31: blank.
- dp output = ~dp_reg[index] during S_ON, otherwise 1.

Optional Feature:
- Macro SEG7_SCAN_BLINK_EN.
- When defined:
  - Adds input blink_mask [7:0].
  - A free-running counter toggles a blink phase every BLINK_CNT+1 clocks; phase resets to 0 (visible).
  - In the hidden phase, digits with blink_mask[k]=1 behave as blank (anode still scanned, seg=7'h7F, dp=1).
  - The phase is sampled at each S_BLANK->S_ON transition, so a slot never changes mid-slot.
- When undefined: no blink_mask port and no blink counter; behaviour is exactly as above.

Test Plan:
- SIMULATE=1, reset low 3 cycles then high -> anode=8'hFF, seg=7'h7F for 1 cycle, then anode=8'hFE with seg=7'h7F (blank code 23); anode steps FE,FD,...,7F every 5 cycles with a 1-cycle FF gap; frame_start period is 40 cycles.
- load_req=1 with digits_in codes 0..7, dp_in=8'h01 -> load_ack single pulse at the frame boundary.
  - Next frame, digit 0 shows seg=7'h40 ("0") with dp=0; digit 1 shows seg=7'h79 ("1"); digit 7 shows 7'h78 ("7").
- digits_in changed mid-frame with load_req low -> no display change; with load_req raised at slot 3, capture happens only at the boundary and digits 4-7 of the current frame keep their old values.
- Codes 16..22 and 25 loaded -> seg = 7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F, 7'h7F.
- Reset asserted during S_ON of digit 5 with load_req pending -> outputs return to reset values asynchronously, no load_ack, display registers blank after release.
- SEG7_SCAN_BLINK_EN, blink_mask=8'h02, digits loaded -> digit 1 blank in alternate 8-cycle phases, never toggling within a slot; other digits unaffected.

Source files
------------

// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler
// Scans an 8-digit, active-low seven-segment display. Each slot is a short
// all-off blanking gap followed by one lit digit. Producers hand over a full
// set of eight digit codes through a level req / pulse ack handshake, and the
// codes are only taken at the frame boundary so a frame never shows a mix of
// old and new digits.
// Optional feature: define SEG7_SCAN_BLINK_EN to add the blink_mask input and
// the free-running blink phase.
module seg7_scan_scheduler #(
    parameter bit SIMULATE  = 1'b0,
    parameter int ON_CYC    = SIMULATE ? 4 : 99_000,
    parameter int BLANK_CYC = SIMULATE ? 1 : 1_000
`ifdef SEG7_SCAN_BLINK_EN
    ,
    parameter int BLINK_CNT = SIMULATE ? 7 : 24_999_999
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic        load_req,
`ifdef SEG7_SCAN_BLINK_EN
    input  logic [7:0]  blink_mask,
`endif
    output logic        load_ack,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic {
        S_BLANK,
        S_ON
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_index;
    logic [4:0]       r_code [8];
    logic [7:0]       r_dpReg;
    logic             w_slotDone;
    logic             w_capture;
    logic             w_hidden;
    logic [6:0]       w_segDecoded;

    // Code to active-low cathodes: hex glyphs, then single segments a..g,
    // everything above 22 is blank.
    function automatic logic [6:0] decodeSeg(input logic [4:0] code);
        logic [6:0] s;
        s = 7'h7F;
        case (code)
            5'd0:    s = 7'h40;
            5'd1:    s = 7'h79;
            5'd2:    s = 7'h24;
            5'd3:    s = 7'h30;
            5'd4:    s = 7'h19;
            5'd5:    s = 7'h12;
            5'd6:    s = 7'h02;
            5'd7:    s = 7'h78;
            5'd8:    s = 7'h00;
            5'd9:    s = 7'h10;
            5'd10:   s = 7'h08;
            5'd11:   s = 7'h03;
            5'd12:   s = 7'h46;
            5'd13:   s = 7'h21;
            5'd14:   s = 7'h06;
            5'd15:   s = 7'h0E;
            5'd16:   s = 7'h7E;
            5'd17:   s = 7'h7D;
            5'd18:   s = 7'h7B;
            5'd19:   s = 7'h77;
            5'd20:   s = 7'h6F;
            5'd21:   s = 7'h5F;
            5'd22:   s = 7'h3F;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Next state: each phase ends when its cycle counter reaches its last count.
    always_comb begin
        w_nextState = r_state;
        w_slotDone  = 1'b0;
        case (r_state)
            S_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_slotDone  = 1'b1;
                    w_nextState = S_ON;
                end
            end
            S_ON: begin
                if (r_cnt == ON_LAST) begin
                    w_slotDone  = 1'b1;
                    w_nextState = S_BLANK;
                end
            end
            default: w_nextState = S_BLANK;
        endcase
    end

    // The frame boundary is the final lit cycle of digit 7.
    assign w_capture    = (r_state == S_ON) && w_slotDone && (r_index == 3'd7) && load_req;
    assign w_segDecoded = decodeSeg(r_code[r_index]);

    // State register, phase counter and digit index (index advances leaving S_ON).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_BLANK;
            r_cnt   <= '0;
            r_index <= 3'd0;
        end else begin
            r_state <= w_nextState;
            if (w_slotDone) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == S_ON) && w_slotDone) begin
                r_index <= r_index + 3'd1;
            end
        end
    end

    // Display registers: all eight codes and dp bits are replaced together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) begin
                r_code[k] <= 5'd23;
            end
            r_dpReg <= 8'h00;
        end else if (w_capture) begin
            for (int k = 0; k < 8; k++) begin
                r_code[k] <= digits_in[5*k +: 5];
            end
            r_dpReg <= dp_in;
        end
    end

`ifdef SEG7_SCAN_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CNT + 1);

    logic [BLINK_W-1:0] r_blinkCnt;
    logic               r_blinkPhase;

    // Free-running blink phase; phase 0 is the visible half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (r_blinkCnt == BLINK_W'(BLINK_CNT)) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= ~r_blinkPhase;
        end else begin
            r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
        end
    end

    assign w_hidden = r_blinkPhase & blink_mask[r_index];
`else
    assign w_hidden = 1'b0;
`endif

    // Output registers change only on phase transitions, so a lit slot is
    // frozen for its whole duration (including its blink visibility).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode       <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            load_ack    <= w_capture;
            frame_start <= 1'b0;
            if ((r_state == S_BLANK) && w_slotDone) begin
                anode       <= ~(8'b1 << r_index);
                seg         <= w_hidden ? 7'h7F : w_segDecoded;
                dp          <= w_hidden ? 1'b1 : ~r_dpReg[r_index];
                frame_start <= (r_index == 3'd0);
            end else if ((r_state == S_ON) && w_slotDone) begin
                anode <= 8'hFF;
                seg   <= 7'h7F;
                dp    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb_seg7_scan_scheduler
// Randomised bench for seg7_scan_scheduler (SIMULATE=1: 1 blank + 4 lit cycles
// per slot, 40-cycle frames). The reference model works from elapsed cycles
// since reset release and a copy of the latched digit codes; segment patterns
// come from glyph letter strings. Define SEG7_SCAN_BLINK_EN to also run the
// blink scenario.
module tb_seg7_scan_scheduler;

    localparam int SLOT  = 5;
    localparam int FRAME = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [39:0] digits_in = '0;
    logic [7:0]  dp_in = '0;
    logic        load_req = 1'b0;
`ifdef SEG7_SCAN_BLINK_EN
    logic [7:0]  blink_mask = 8'h00;
`endif
    logic        load_ack;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int         t = -1;
    logic [4:0] mCode [8];
    logic [7:0] mDp = 8'h00;
    logic [7:0] eAnode;
    logic [6:0] eSeg;
    logic       eDp;
    logic       eAck = 1'b0;
    logic       eFs;

    seg7_scan_scheduler #(.SIMULATE(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .load_req    (load_req),
`ifdef SEG7_SCAN_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .load_ack    (load_ack),
        .anode       (anode),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Lit segments from glyph letters, returned active-low.
    function automatic logic [6:0] expSeg(input logic [4:0] code);
        string glyph [16];
        string s;
        logic [6:0] lit;
        int b;
        glyph = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                  "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
        lit = 7'h00;
        if (code < 5'd16) begin
            s = glyph[code];
            for (int i = 0; i < s.len(); i++) begin
                b = int'(s[i]) - 97;
                lit[b] = 1'b1;
            end
        end else if (code <= 5'd22) begin
            b = int'(code) - 16;
            lit[b] = 1'b1;
        end
        return ~lit;
    endfunction

    function automatic logic [39:0] packCodes(input logic [4:0] c0, input logic [4:0] c1,
                                              input logic [4:0] c2, input logic [4:0] c3,
                                              input logic [4:0] c4, input logic [4:0] c5,
                                              input logic [4:0] c6, input logic [4:0] c7);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    function automatic logic [39:0] randCodes();
        logic [39:0] v;
        for (int k = 0; k < 8; k++) v[5*k +: 5] = 5'($urandom_range(0, 31));
        return v;
    endfunction

    // Advance the model by one clock and derive what the pins should show.
    task automatic stepModel();
        int slot;
        int w;
        @(posedge clk);
        if (!reset) begin
            t = -1;
            eAck = 1'b0;
            for (int k = 0; k < 8; k++) mCode[k] = 5'd23;
            mDp = 8'h00;
        end else begin
            eAck = (t >= 0) && (t % FRAME == FRAME - 2) && (load_req == 1'b1);
            if (eAck) begin
                for (int k = 0; k < 8; k++) mCode[k] = digits_in[5*k +: 5];
                mDp = dp_in;
            end
            t++;
        end
        @(negedge clk);
        eAnode = 8'hFF; eSeg = 7'h7F; eDp = 1'b1; eFs = 1'b0;
        if (t >= 0) begin
            slot = (t / SLOT) % 8;
            w = t % SLOT;
            if (w < SLOT - 1) begin
                eAnode = ~(8'b1 << slot);
                eSeg = expSeg(mCode[slot]);
                eDp = ~mDp[slot];
                eFs = (slot == 0) && (w == 0);
            end
        end
    endtask

    task automatic test_reset();
        int fsT [$];
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_values got %h/%h/%b/%b/%b want ff/7f/1/0/0", anode, seg, dp, load_ack, frame_start);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL scan_after_reset t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
            if (frame_start === 1'b1) fsT.push_back(t);
        end
        checks++;
        if (fsT.size() != 3 || fsT[1] - fsT[0] != FRAME) begin
            failures++;
            $display("FAIL frame_period got %0d pulses want 3 pulses 40 apart", fsT.size());
        end
    endtask

    task automatic test_load();
        bit acked = 0;
        digits_in = packCodes(5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7);
        dp_in = 8'h01;
        load_req = 1'b1;
        for (int i = 0; i < 2 * FRAME && !acked; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL load t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
            if (load_ack === 1'b1) begin
                acked = 1;
                load_req = 1'b0;
            end
        end
        checks++;
        if (!acked) begin
            failures++;
            $display("FAIL load_ack_timeout got no ack want ack within 80 cycles");
        end
        for (int i = 0; i < FRAME; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL load_frame t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
            if (anode == 8'hFE && {seg, dp} !== {7'h40, 1'b0}) begin
                failures++;
                $display("FAIL digit0_glyph got %h/%b want 40/0", seg, dp);
            end
            if (anode == 8'h7F && seg !== 7'h78) begin
                failures++;
                $display("FAIL digit7_glyph got %h want 78", seg);
            end
        end
    endtask

    task automatic test_midframe();
        bit acked = 0;
        for (int i = 0; i < FRAME; i++) begin
            digits_in = randCodes();
            dp_in = 8'($urandom);
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL midframe_noreq t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
        end
        while (t % FRAME != 3 * SLOT - 1) stepModel();
        digits_in = randCodes();
        dp_in = 8'($urandom);
        load_req = 1'b1;
        for (int i = 0; i < 2 * FRAME && !acked; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL midframe_req t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
            if (load_ack === 1'b1) begin
                acked = 1;
                load_req = 1'b0;
            end
        end
        checks++;
        if (!acked) begin
            failures++;
            $display("FAIL midframe_ack_timeout got no ack want ack at boundary");
        end
        for (int i = 0; i < FRAME; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL midframe_after t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
        end
    endtask

    task automatic test_single_segments();
        bit acked = 0;
        logic [6:0] want [8];
        want = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F, 7'h7F};
        digits_in = packCodes(5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd25);
        dp_in = 8'($urandom);
        load_req = 1'b1;
        for (int i = 0; i < 2 * FRAME && !acked; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL segs_load t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
            if (load_ack === 1'b1) begin
                acked = 1;
                load_req = 1'b0;
            end
        end
        checks++;
        if (!acked) begin
            failures++;
            $display("FAIL segs_ack_timeout got no ack want ack at boundary");
        end
        for (int i = 0; i < FRAME; i++) begin
            stepModel();
            for (int k = 0; k < 8; k++) begin
                if (anode == ~(8'b1 << k)) begin
                    checks++;
                    if (seg !== want[k]) begin
                        failures++;
                        $display("FAIL single_seg digit=%0d got %h want %h", k, seg, want[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        digits_in = randCodes();
        dp_in = 8'($urandom);
        load_req = 1'b1;
        for (int i = 0; i < 3 * FRAME && acks < 2; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL back_to_back t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
            if (load_ack === 1'b1) begin
                acks++;
                if (acks == 2) load_req = 1'b0;
            end
        end
        checks++;
        if (acks != 2) begin
            failures++;
            $display("FAIL back_to_back_acks got %0d want 2", acks);
        end
    endtask

    task automatic test_async_reset();
        digits_in = randCodes();
        dp_in = 8'($urandom);
        while (t % FRAME != 4 * SLOT - 1) stepModel();
        load_req = 1'b1;
        while (t % FRAME != 5 * SLOT + 1) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL pre_reset t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({anode, seg, dp, load_ack, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got %h/%h/%b/%b/%b want ff/7f/1/0/0", anode, seg, dp, load_ack, frame_start);
        end
        stepModel();
        stepModel();
        load_req = 1'b0;
        stepModel();
        reset = 1'b1;
        for (int i = 0; i < FRAME + 5; i++) begin
            stepModel();
            checks++;
            if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                failures++;
                $display("FAIL post_reset t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                         t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
            end
        end
    endtask

    task automatic test_random();
        bit acked;
        int gap;
        for (int r = 0; r < 3; r++) begin
            acked = 0;
            gap = $urandom_range(0, FRAME - 1);
            for (int i = 0; i < gap; i++) stepModel();
            digits_in = randCodes();
            dp_in = 8'($urandom);
            load_req = 1'b1;
            for (int i = 0; i < 3 * FRAME && !acked; i++) begin
                stepModel();
                checks++;
                if ({anode, seg, dp, load_ack, frame_start} !== {eAnode, eSeg, eDp, eAck, eFs}) begin
                    failures++;
                    $display("FAIL random r=%0d t=%0d got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                             r, t, anode, seg, dp, load_ack, frame_start, eAnode, eSeg, eDp, eAck, eFs);
                end
                if (load_ack === 1'b1) begin
                    acked = 1;
                    load_req = 1'b0;
                end
            end
            checks++;
            if (!acked) begin
                failures++;
                $display("FAIL random_ack_timeout r=%0d got no ack", r);
            end
        end
    endtask

`ifdef SEG7_SCAN_BLINK_EN
    task automatic test_blink();
        bit acked = 0;
        logic [6:0] slotSeg [4];
        logic [6:0] first;
        int f = 0;
        blink_mask = 8'h02;
        digits_in = packCodes(5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd8);
        dp_in = 8'h00;
        load_req = 1'b1;
        for (int i = 0; i < 2 * FRAME && !acked; i++) begin
            stepModel();
            if (load_ack === 1'b1) begin
                acked = 1;
                load_req = 1'b0;
            end
        end
        checks++;
        if (!acked) begin
            failures++;
            $display("FAIL blink_ack_timeout got no ack");
        end
        first = 7'h00;
        for (int i = 0; i < 4 * FRAME; i++) begin
            stepModel();
            if (((t / SLOT) % 8) == 1 && (t % SLOT) < SLOT - 1) begin
                checks++;
                if (anode !== 8'hFD || ((t % SLOT) != 0 && seg !== first)) begin
                    failures++;
                    $display("FAIL blink_slot t=%0d got %h/%h want fd/%h", t, anode, seg, first);
                end
                if ((t % SLOT) == 0) first = seg;
                if ((t % SLOT) == SLOT - 2 && f < 4) begin
                    slotSeg[f] = seg;
                    f++;
                end
            end else begin
                checks++;
                if ({anode, seg, dp} !== {eAnode, eSeg, eDp}) begin
                    failures++;
                    $display("FAIL blink_other t=%0d got %h/%h/%b want %h/%h/%b", t, anode, seg, dp, eAnode, eSeg, eDp);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (slotSeg[k] === slotSeg[k+1] || (slotSeg[k] !== 7'h7F && slotSeg[k] !== expSeg(5'd8))) begin
                failures++;
                $display("FAIL blink_alternate frame=%0d got %h then %h want alternating 00/7f", k, slotSeg[k], slotSeg[k+1]);
            end
        end
        blink_mask = 8'h00;
    endtask
`endif

    initial begin
        for (int k = 0; k < 8; k++) mCode[k] = 5'd23;
        test_reset();
        test_load();
        test_midframe();
        test_single_segments();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef SEG7_SCAN_BLINK_EN
        test_blink();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
